// File: rtl/qam16_sym2bit.sv
// qam16_sym2bit: buffers recovered QAM16 symbol codes and re-serialises them MSB-first; optional `QAM16_GRAY_DEMAP_EN Gray-to-binary demap on write
module qam16_sym2bit #(
    parameter int BIT_DIV = 2,
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         code,
    input  logic               code_vld,
    input  logic               ovf_clr,
    output logic               dout,
    output logic               dout_vld,
    output logic               busy,
    output logic               ovf,
    output logic [FIFO_AW:0]   fifo_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t             state, state_n;
    logic [3:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [3:0]         shreg, shreg_n, wdata;
    logic [1:0]         bit_idx, idx_n;
    logic [4:0]         div_cnt, div_n;
    logic               pop, full, wr_en, ovf_set;

`ifdef QAM16_GRAY_DEMAP_EN
    assign wdata = {code[3], code[3] ^ code[2], code[1], code[1] ^ code[0]};
`else
    assign wdata = code;
`endif
    assign full    = fifo_cnt == (FIFO_AW+1)'(DEPTH);
    assign wr_en   = code_vld & (~full | pop);
    assign ovf_set = code_vld & full & ~pop;

    // symbol storage; flushed logically by resetting the pointers
    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= wdata;

    // FIFO pointers, occupancy and sticky overflow (set beats clear)
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
            fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(pop);
            ovf      <= ovf_set | (ovf & ~ovf_clr);
        end

    // next-state: pop into the shift register from IDLE or back-to-back at the end of bit 0
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = bit_idx;
        div_n   = div_cnt;
        pop     = 1'b0;
        if (state == IDLE) begin
            if (fifo_cnt != '0) begin
                pop     = 1'b1;
                shreg_n = mem[rd_ptr];
                idx_n   = 2'd3;
                div_n   = '0;
                state_n = SHIFT;
            end
        end else if (div_cnt != 5'(BIT_DIV - 1)) begin
            div_n = div_cnt + 5'd1;
        end else begin
            div_n = '0;
            if (bit_idx != 2'd0) begin
                shreg_n = {shreg[2:0], 1'b0};
                idx_n   = bit_idx - 2'd1;
            end else if (fifo_cnt != '0) begin
                pop     = 1'b1;
                shreg_n = mem[rd_ptr];
                idx_n   = 2'd3;
            end else begin
                state_n = IDLE;
            end
        end
    end

    // state and outputs registered from next-state values so outputs align with the loaded bit
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            div_cnt  <= '0;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_idx  <= idx_n;
            div_cnt  <= div_n;
            dout     <= (state_n == SHIFT) & shreg_n[3];
            dout_vld <= (state_n == SHIFT) && (div_n == '0);
            busy     <= state_n == SHIFT;
        end
endmodule

// File: doc/qam16_sym2bit.md
Name: qam16_sym2bit

Overview:
- Receive-side parallel-to-serial converter: the inverse of the transmit bit-to-symbol mapper.
- Takes recovered 4-bit QAM16 symbol codes (I bits [3:2], Q bits [1:0]) from the demodulator/slicer, buffers them in a small FIFO, and re-serialises them MSB-first into a single-bit stream at BIT_DIV clocks per bit.
- Default BIT_DIV=2 gives 1 symbol per 8 clk, restoring the original bit rate. Output feeds the downstream bit sink / BER checker.

Parameters:
- BIT_DIV, 2, clocks per output bit (legal range 1..16).
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW (default 4 symbols).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- code  in  4  recovered symbol; code[3] is the oldest bit.
- code_vld  in  1  single-cycle strobe; code is sampled when high.
- ovf_clr  in  1  synchronous clear of ovf.
- dout  out  1  serial bit.
- dout_vld  out  1  one-cycle pulse on the first clock of each output bit.
- busy  out  1  high while a symbol is being shifted out.
- ovf  out  1  sticky overflow flag.
- fifo_cnt  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst=1): dout=0, dout_vld=0, busy=0, ovf=0, fifo_cnt=0; FSM=IDLE; all pointers and counters 0. Reset mid-symbol abandons the symbol and flushes the FIFO; no partial bits after release.
- FIFO write: at the edge where code_vld=1.
  - If not full, code is written.
  - If full and no pop on the same edge, the symbol is dropped, ovf<=1, and fifo_cnt is unchanged.
  - If full with a simultaneous pop, the write is accepted and there is no overflow.
- ovf: sticky; cleared only by rst or ovf_clr. If ovf_clr and a new overflow occur on the same edge, set wins.
- Pointers wrap modulo depth. fifo_cnt is +1 on write only, -1 on pop only, and unchanged on simultaneous write and pop.
- FSM states:
  - IDLE: busy=0, dout=0, dout_vld=0. If fifo_cnt!=0, pop the head into the 4-bit shift register, load bit_idx=3 and div_cnt=0, and go to SHIFT on the same edge. A write to an empty FIFO is not visible until the next edge, so there is no bypass.
  - SHIFT: dout=shreg[3], held for BIT_DIV clocks. dout_vld=1 only when div_cnt==0. div_cnt counts 0..BIT_DIV-1; at BIT_DIV-1 shreg shifts left and bit_idx decrements.
  - At the last clock of bit_idx=0:
    - if fifo_cnt!=0, pop and reload in place (stay in SHIFT, no gap cycle);
    - else go to IDLE.
- Latency: code_vld at edge E0 → written at E0, popped at E1 → dout/dout_vld valid in the cycle after E1 (2 clk).
- Continuous input at 1 symbol per 4*BIT_DIV clk gives a gapless output with a dout_vld pulse every BIT_DIV clk. With BIT_DIV=1, dout_vld stays high continuously while streaming.
- Bit order: code[3], code[2], code[1], code[0].
- All outputs are registered.

Optional Feature:
- Macro: QAM16_GRAY_DEMAP_EN.
- Defined: each 2-bit axis is Gray-to-binary converted on FIFO write. The stored value is {g3, g3^g2, g1, g1^g0}.
- Undefined: code is stored unchanged.
- Timing and latency are identical in both builds.

Test Plan:
- Single symbol, BIT_DIV=2: code=4'b1011 pulsed once.
  - dout sequence 1,1,0,0,1,1,1,1 starting 2 clk after the strobe.
  - dout_vld high on clk 0, 2, 4, 6 of that sequence.
  - busy high for exactly 8 clk, then IDLE with dout=0.
- Continuous stream: 1011, 0110, 1111 strobed every 8 clk → 12 bits 1011 0110 1111 with no gap; busy stays high for 24 clk.
- Overflow: 6 back-to-back code_vld pulses (A..F) on consecutive clk, BIT_DIV=2.
  - A..E are serialised in order and F is dropped.
  - ovf=1 and fifo_cnt peaks at 4.
  - ovf_clr pulse → ovf=0.
- Reset mid-operation: assert rst during bit 2 of a symbol with 2 symbols queued → outputs 0 immediately, fifo_cnt=0, no further dout_vld after release until a new strobe.
- BIT_DIV=1: symbols 1001, 0101 on consecutive strobes every 4 clk → dout 1,0,0,1,0,1,0,1 with dout_vld continuously high for 8 clk.
- QAM16_GRAY_DEMAP_EN defined: code=4'b1110 → dout 1,0,1,1; undefined → 1,1,1,0.
